// File: rtl/instr_ctrl_seq.sv
// Instruction-side control sequencer: latches one instruction, steps one-hot ticks T0..T3 and drives datapath strobes.
// Optional retire counter port enabled by defining INSTR_CTRL_SEQ_RETIRE_CNT_EN.
module instr_ctrl_seq #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  input  logic              zero_flag,
  input  logic              mem_ack,
  output logic [3:0]        tick,
  output logic [DATA_W-1:0] ir,
  output logic [REG_AW-1:0] rx_sel,
  output logic [REG_AW-1:0] ry_sel,
  output logic [DATA_W-1:0] imm_ext,
  output logic              rf_rd_en,
  output logic [1:0]        alu_op,
  output logic              alu_b_imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic              rf_we,
  output logic              done
`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
  ,
  output logic [DATA_W-1:0] retire_cnt
`endif
);

  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0010;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b1000;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MVI  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  logic [2:0] opcode;
  logic       is_mem;

  assign opcode  = ir[DATA_W-1 -: 3];
  assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
  assign rx_sel  = ir[IMM_W+REG_AW-1 : IMM_W];
  assign ry_sel  = ir[IMM_W-1 -: REG_AW];
  assign imm_ext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Ready is held low during reset so nothing is accepted until the first cycle after rst drops.
  assign instr_ready = (tick == T0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= T0;
      ir   <= '0;
    end else begin
      case (tick)
        T0: if (instr_valid && instr_ready) begin
              ir   <= instr;
              tick <= T1;
            end
        T1: tick <= T2;
        T2: if (!is_mem || mem_ack) tick <= T3;
        T3: tick <= T0;
        default: tick <= T0;
      endcase
    end
  end

  // Strobes decode from tick and ir; an illegal tick encoding leaves every strobe low.
  always_comb begin
    rf_rd_en  = 1'b0;
    alu_op    = 2'b00;
    alu_b_imm = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    case (tick)
      T1: rf_rd_en = 1'b1;
      T2: begin
        case (opcode)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          OP_AND:  alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
        alu_b_imm = (opcode == OP_MVI);
        mem_req   = is_mem;
        mem_we    = (opcode == OP_ST);
      end
      T3: begin
        done = 1'b1;
        case (opcode)
          OP_ST:   rf_we = 1'b0;
          OP_MVNZ: rf_we = ~zero_flag;
          OP_MV, OP_ADD, OP_SUB, OP_MVI, OP_LD, OP_AND: rf_we = 1'b1;
          default: rf_we = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
  // Free-running retire count; wraps naturally at the top of its range.
  always_ff @(posedge clk) begin
    if (rst) retire_cnt <= '0;
    else if (done) retire_cnt <= retire_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_ctrl_seq.sv
// Scoreboard bench for instr_ctrl_seq: expected per-cycle strobe vectors are queued per instruction and popped each cycle.
// Also exercises retire_cnt when INSTR_CTRL_SEQ_RETIRE_CNT_EN is defined.
module tb_instr_ctrl_seq;

  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0010;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        zero_flag;
  logic        mem_ack;
  logic [3:0]  tick;
  logic [15:0] ir;
  logic [3:0]  rx_sel;
  logic [3:0]  ry_sel;
  logic [15:0] imm_ext;
  logic        rf_rd_en;
  logic [1:0]  alu_op;
  logic        alu_b_imm;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic        done;
`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int retires  = 0;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;
  exp_t sbq[$];

  instr_ctrl_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .tick(tick), .ir(ir), .rx_sel(rx_sel), .ry_sel(ry_sel), .imm_ext(imm_ext),
    .rf_rd_en(rf_rd_en), .alu_op(alu_op), .alu_b_imm(alu_b_imm),
    .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .done(done)
`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected {tick, rf_rd_en, alu_op, alu_b_imm, mem_req, mem_we, rf_we, done} for one cycle.
  function automatic logic [11:0] expv(input logic [3:0] t, input logic [2:0] op, input logic z);
    logic       rd, bimm, req, we, rfwe, dn;
    logic [1:0] alu;
    rd   = (t == T1);
    alu  = 2'b00;
    if (t == T2) begin
      if (op == 3'b001) alu = 2'b01;
      else if (op == 3'b010) alu = 2'b10;
      else if (op == 3'b111) alu = 2'b11;
    end
    bimm = (t == T2) && (op == 3'b011);
    req  = (t == T2) && (op == 3'b100 || op == 3'b101);
    we   = (t == T2) && (op == 3'b101);
    dn   = (t == T3);
    if (t != T3) rfwe = 1'b0;
    else if (op == 3'b110) rfwe = ~z;
    else rfwe = (op != 3'b101);
    return {t, rd, alu, bimm, req, we, rfwe, dn};
  endfunction

  function automatic logic [11:0] observed();
    return {tick, rf_rd_en, alu_op, alu_b_imm, mem_req, mem_we, rf_we, done};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction; ld/st get 'waits' extra T2 cycles, hold keeps instr_valid high with junk instr after T0.
  task automatic applyStimulus(input string name, input logic [15:0] w, input int waits,
                               input logic z, input logic hold);
    logic [2:0] op;
    logic       ismem;
    int         nt2;
    int         cyc;
    exp_t       e;
    op    = w[15:13];
    ismem = (op == 3'b100) || (op == 3'b101);
    nt2   = ismem ? waits + 1 : 1;
    sbq.push_back('{{name, "_T0"}, expv(T0, op, z)});
    sbq.push_back('{{name, "_T1"}, expv(T1, op, z)});
    for (int i = 0; i < nt2; i++) sbq.push_back('{{name, "_T2"}, expv(T2, op, z)});
    sbq.push_back('{{name, "_T3"}, expv(T3, op, z)});
    cyc = 0;
    while (sbq.size() > 0) begin
      e           = sbq.pop_front();
      instr_valid = (cyc == 0) || hold;
      instr       = (cyc == 0) ? w : 16'($urandom);
      zero_flag   = z;
      mem_ack     = (cyc <= 1) || (cyc == 1 + nt2);
      #4;
      checkOutput(e.tag, 32'(observed()), 32'(e.v));
      if (cyc == 0) begin
        checkOutput({name, "_ready"}, 32'(instr_ready), 32'd1);
      end else begin
        checkOutput({name, "_ir"}, 32'(ir), 32'(w));
        checkOutput({name, "_notready"}, 32'(instr_ready), 32'd0);
      end
      if (cyc == 1) begin
        checkOutput({name, "_rx"}, 32'(rx_sel), 32'(w[12:9]));
        checkOutput({name, "_ry"}, 32'(ry_sel), 32'(w[8:5]));
        checkOutput({name, "_imm"}, 32'(imm_ext), 32'({{7{w[8]}}, w[8:0]}));
      end
      nextCycle();
      cyc++;
    end
    retires++;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    #4;
    checkOutput({name, "_backT0"}, 32'(tick), 32'(T0));
`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
    checkOutput({name, "_retire"}, 32'(retire_cnt), 32'(retires));
`endif
    nextCycle();
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0;
    zero_flag   = 1'b0;
    mem_ack     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #4;
    sbq.push_back('{"reset", expv(T0, 3'b000, 1'b0)});
    checkOutput(sbq[0].tag, 32'(observed()), 32'(sbq[0].v));
    void'(sbq.pop_front());
    checkOutput("reset_ir", 32'(ir), 32'd0);
    checkOutput("reset_ready", 32'(instr_ready), 32'd0);
    nextCycle();
    rst = 1'b0;
    #4;
    checkOutput("post_reset_ready", 32'(instr_ready), 32'd1);
    nextCycle();

    applyStimulus("add",    16'h2240, 0, 1'b0, 1'b0);
    applyStimulus("mvi",    16'h67FF, 0, 1'b0, 1'b0);
    applyStimulus("ld",     16'h88A0, 2, 1'b0, 1'b0);
    applyStimulus("mvnz_z", 16'hC240, 0, 1'b1, 1'b0);
    applyStimulus("mvnz_n", 16'hC240, 0, 1'b0, 1'b0);
    applyStimulus("sub",    16'h4A60, 0, 1'b0, 1'b0);
    applyStimulus("and",    16'hE2C0, 0, 1'b1, 1'b0);
    applyStimulus("st",     16'hA240, 0, 1'b0, 1'b0);
    applyStimulus("mvhold", 16'h0420, 0, 1'b0, 1'b1);

    // st with rst pulsed in its second T2 cycle.
    sbq.push_back('{"rst_T0",  expv(T0, 3'b101, 1'b0)});
    sbq.push_back('{"rst_T1",  expv(T1, 3'b101, 1'b0)});
    sbq.push_back('{"rst_T2a", expv(T2, 3'b101, 1'b0)});
    sbq.push_back('{"rst_T2b", expv(T2, 3'b101, 1'b0)});
    sbq.push_back('{"rst_after", expv(T0, 3'b000, 1'b0)});
    for (int c = 0; c < 5; c++) begin
      exp_t e;
      e           = sbq.pop_front();
      instr_valid = (c == 0);
      instr       = 16'hA240;
      mem_ack     = 1'b0;
      rst         = (c == 3);
      #4;
      checkOutput(e.tag, 32'(observed()), 32'(e.v));
      if (c == 3) checkOutput("rst_ready_low", 32'(instr_ready), 32'd0);
      if (c == 4) begin
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_ready", 32'(instr_ready), 32'd1);
      end
      nextCycle();
    end
    retires = 0;
`ifdef INSTR_CTRL_SEQ_RETIRE_CNT_EN
    checkOutput("rst_retire", 32'(retire_cnt), 32'd0);
`endif
    applyStimulus("add2", 16'h2240, 0, 1'b0, 1'b0);
    applyStimulus("ld0",  16'h88A0, 0, 1'b0, 1'b0);
    applyStimulus("mvi2", 16'h6601, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
